// File: rtl/blob_pkg.sv
// Shared types and helper functions for the blob rasterizer.
package blob_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        DRAW   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // True when offset (dx,dy) lies inside the clipped diamond sprite.
    function automatic logic in_sprite(input int dx, input int dy, input int radius, input int corner);
        int adx;
        int ady;
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        return (adx <= radius) && (ady <= radius) && ((adx + ady) <= corner);
    endfunction

    // Fixed-point coordinate to signed cell index (arithmetic shift keeps negatives negative).
    function automatic int cell_of(input int coord, input int frac_bits);
        return coord >>> frac_bits;
    endfunction

endpackage

// File: rtl/blob_rasterizer_frame_timer.sv
// Free-running frame timer: emits a one-cycle tick every FRAME_CYCLES enabled clocks.
module frame_timer #(
    parameter int FRAME_CYCLES = 10000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

    logic [CNT_W-1:0] count_r;

    assign tick = enable && (count_r == CNT_W'(FRAME_CYCLES - 1));

    // Count enabled cycles, wrap on tick, hold while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (tick) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + 1'b1;
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/blob_rasterizer.sv
// Snapshots particle positions on each frame tick, draws one diamond-sprite cell per cycle
// into a back buffer and commits the finished buffer to the front matrix.
module blob_rasterizer
    import blob_pkg::*;
#(
    parameter int N_PART       = 4,
    parameter int COORD_W      = 12,
    parameter int FRAC_BITS    = 4,
    parameter int GRID_W       = 16,
    parameter int GRID_H       = 16,
    parameter int RADIUS       = 2,
    parameter int CORNER       = 3,
    parameter int FRAME_CYCLES = 10000,
    parameter bit CHECK_LAT    = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [N_PART*COORD_W-1:0]   pos_x,
    input  logic [N_PART*COORD_W-1:0]   pos_y,
    input  logic [N_PART-1:0]           part_valid,
    output logic [GRID_W*GRID_H-1:0]    matrix,
    output logic                        frame_done,
    output logic                        busy,
    output logic                        overrun
);

    localparam int CELL_W    = COORD_W - FRAC_BITS + 1;
    localparam int SIDE      = 2 * RADIUS + 1;
    localparam int FRAME_LAT = 2 + N_PART * SIDE * SIDE;
    localparam int NCELL     = GRID_W * GRID_H;
    localparam int IDX_W     = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam int PIDX_W    = (N_PART > 1) ? $clog2(N_PART) : 1;
    localparam int OFF_W     = $clog2(RADIUS + 1) + 2;
    localparam logic signed [OFF_W-1:0] NEG_R = OFF_W'(-RADIUS);
    localparam logic signed [OFF_W-1:0] POS_R = OFF_W'(RADIUS);

    // A frame period shorter than the render latency would drop every other frame.
    if (CHECK_LAT && (FRAME_CYCLES <= FRAME_LAT)) begin : g_lat_check
        $error("blob_rasterizer: FRAME_CYCLES must exceed FRAME_LAT");
    end

    state_t                       state_r;
    state_t                       state_s;
    logic                         tick_s;
    logic [N_PART*COORD_W-1:0]    sx_snap_r;
    logic [N_PART*COORD_W-1:0]    sy_snap_r;
    logic [N_PART-1:0]            valid_snap_r;
    logic [PIDX_W-1:0]            p_r;
    logic signed [OFF_W-1:0]      dx_r;
    logic signed [OFF_W-1:0]      dy_r;
    logic [NCELL-1:0]             back_r;
    logic [NCELL-1:0]             matrix_r;
    logic                         frame_done_r;
    logic                         overrun_r;
    logic signed [COORD_W-1:0]    sx_cur_s;
    logic signed [COORD_W-1:0]    sy_cur_s;
    logic signed [CELL_W-1:0]     cx_s;
    logic signed [CELL_W-1:0]     cy_s;
    logic [IDX_W-1:0]             idx_s;
    logic                         hit_s;
    logic                         last_s;

    frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick_s)
    );

    assign sx_cur_s = sx_snap_r[p_r*COORD_W +: COORD_W];
    assign sy_cur_s = sy_snap_r[p_r*COORD_W +: COORD_W];

    // Evaluate the current sprite cell: grid position, visibility and end-of-draw.
    always_comb begin
        cx_s   = CELL_W'(cell_of(int'(sx_cur_s), FRAC_BITS) + int'(dx_r));
        cy_s   = CELL_W'(cell_of(int'(sy_cur_s), FRAC_BITS) + int'(dy_r));
        idx_s  = IDX_W'(int'(cy_s) * GRID_W + int'(cx_s));
        hit_s  = valid_snap_r[p_r]
              && in_sprite(int'(dx_r), int'(dy_r), RADIUS, CORNER)
              && (int'(cx_s) >= 0) && (int'(cx_s) < GRID_W)
              && (int'(cy_s) >= 0) && (int'(cy_s) < GRID_H);
        last_s = (p_r == PIDX_W'(N_PART - 1)) && (dx_r == POS_R) && (dy_r == POS_R);
    end

    // Frame sequencing: IDLE -> CLEAR -> DRAW -> COMMIT -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (tick_s) state_s = CLEAR; else state_s = IDLE;
            CLEAR:   state_s = DRAW;
            DRAW:    if (last_s) state_s = COMMIT; else state_s = DRAW;
            COMMIT:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Snapshot, sprite walk, back-buffer writes, commit and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sx_snap_r    <= '0;
            sy_snap_r    <= '0;
            valid_snap_r <= '0;
            p_r          <= '0;
            dx_r         <= '0;
            dy_r         <= '0;
            back_r       <= '0;
            matrix_r     <= '0;
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            overrun_r    <= tick_s && (state_r != IDLE);
            case (state_r)
                IDLE: begin
                    if (tick_s) begin
                        sx_snap_r    <= pos_x;
                        sy_snap_r    <= pos_y;
                        valid_snap_r <= part_valid;
                    end
                end
                CLEAR: begin
                    back_r <= '0;
                    p_r    <= '0;
                    dx_r   <= NEG_R;
                    dy_r   <= NEG_R;
                end
                DRAW: begin
                    if (hit_s) begin
                        back_r <= back_r | (NCELL'(1) << idx_s);
                    end
                    // dx fastest, then dy, then particle.
                    if (dx_r == POS_R) begin
                        dx_r <= NEG_R;
                        if (dy_r == POS_R) begin
                            dy_r <= NEG_R;
                            p_r  <= p_r + 1'b1;
                        end else begin
                            dy_r <= dy_r + 1'b1;
                        end
                    end else begin
                        dx_r <= dx_r + 1'b1;
                    end
                end
                COMMIT: begin
                    matrix_r     <= back_r;
                    frame_done_r <= 1'b1;
                end
                default: begin
                    back_r <= back_r;
                end
            endcase
        end
    end

    assign matrix     = matrix_r;
    assign frame_done = frame_done_r;
    assign busy       = (state_r != IDLE);
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_blob_rasterizer.sv
// Directed bench for blob_rasterizer: sprite shapes, clipping, frame timing, snapshot, overrun, reset abort.
module tb_blob_rasterizer;

    localparam int NP = 4;
    localparam int CW = 12;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable_a;
    logic             enable_b;
    logic [NP*CW-1:0] pos_x;
    logic [NP*CW-1:0] pos_y;
    logic [NP-1:0]    part_valid;
    logic [255:0]     matrix_a;
    logic [255:0]     matrix_b;
    logic             fd_a, busy_a, ov_a;
    logic             fd_b, busy_b, ov_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    blob_rasterizer #(.FRAME_CYCLES(200)) dut_a (
        .clk(clk), .reset(reset), .enable(enable_a),
        .pos_x(pos_x), .pos_y(pos_y), .part_valid(part_valid),
        .matrix(matrix_a), .frame_done(fd_a), .busy(busy_a), .overrun(ov_a)
    );

    blob_rasterizer #(.FRAME_CYCLES(50), .CHECK_LAT(1'b0)) dut_b (
        .clk(clk), .reset(reset), .enable(enable_b),
        .pos_x(pos_x), .pos_y(pos_y), .part_valid(part_valid),
        .matrix(matrix_b), .frame_done(fd_b), .busy(busy_b), .overrun(ov_b)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] with_row(input logic [255:0] m, input int y, input logic [15:0] mask);
        logic [255:0] r;
        r = m;
        r[y*16 +: 16] = mask;
        return r;
    endfunction

    task automatic set_part(input int i, input int x, input int y);
        pos_x[i*CW +: CW] = CW'(x);
        pos_y[i*CW +: CW] = CW'(y);
    endtask

    // Waits for a frame on dut_a; scrambles the inputs once the frame has started.
    task automatic run_frame(output int n_busy, output int n_done);
        int n;
        n = 0;
        n_busy = -1;
        n_done = -1;
        while ((n < 600) && (n_done < 0)) begin
            @(posedge clk); #1;
            n++;
            if (busy_a && (n_busy < 0)) begin
                n_busy = n;
                for (int i = 0; i < NP; i++) set_part(i, 64, 64);
                part_valid = 4'hF;
            end
            if (fd_a) n_done = n;
        end
    endtask

    logic [255:0] exp1, exp2, exp3, exp4;
    int nb, nd, n, first_ov, ov_cnt, fd1, fd2;
    logic ov_at_101;

    initial begin
        exp1 = '0;
        exp1 = with_row(exp1, 6, 16'h0380);
        exp1 = with_row(exp1, 7, 16'h07C0);
        exp1 = with_row(exp1, 8, 16'h07C0);
        exp1 = with_row(exp1, 9, 16'h07C0);
        exp1 = with_row(exp1, 10, 16'h0380);
        exp2 = '0;
        exp2 = with_row(exp2, 0, 16'h0007);
        exp2 = with_row(exp2, 1, 16'h0007);
        exp2 = with_row(exp2, 2, 16'h0003);
        exp3 = '0;
        exp3 = with_row(exp3, 7, 16'h0001);
        exp3 = with_row(exp3, 8, 16'h0001);
        exp3 = with_row(exp3, 9, 16'h0001);
        exp4 = '0;
        exp4 = with_row(exp4, 0, 16'h000E);
        exp4 = with_row(exp4, 1, 16'h007F);
        exp4 = with_row(exp4, 2, 16'h00FF);
        exp4 = with_row(exp4, 3, 16'h00FF);
        exp4 = with_row(exp4, 4, 16'h00FE);
        exp4 = with_row(exp4, 5, 16'h0070);
        exp4 = with_row(exp4, 12, 16'h01C0);
        exp4 = with_row(exp4, 13, 16'hC3E0);
        exp4 = with_row(exp4, 14, 16'hE3E0);
        exp4 = with_row(exp4, 15, 16'hE3E0);

        reset = 1'b1;
        enable_a = 1'b0;
        enable_b = 1'b0;
        pos_x = '0;
        pos_y = '0;
        part_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_matrix", matrix_a, 256'd0);
        chk("reset_frame_done", 256'(fd_a), 256'd0);
        chk("reset_busy", 256'(busy_a), 256'd0);
        chk("reset_overrun", 256'(ov_a), 256'd0);

        // Frame 1: single particle in the middle, timing from reset release.
        @(negedge clk);
        reset = 1'b0;
        set_part(0, 128, 128);
        part_valid = 4'b0001;
        enable_a = 1'b1;
        run_frame(nb, nd);
        chk("f1_busy_edge", 256'(nb), 256'd200);
        chk("f1_done_edge", 256'(nd), 256'd302);
        chk("f1_matrix", matrix_a, exp1);
        chk("f1_popcount", 256'($countones(matrix_a)), 256'd21);
        @(posedge clk); #1;
        chk("f1_done_pulse", 256'(fd_a), 256'd0);

        // Frame 2: top-left corner clip, no wrap.
        for (int i = 0; i < NP; i++) set_part(i, 0, 0);
        part_valid = 4'b0001;
        run_frame(nb, nd);
        chk("f2_busy_edge", 256'(nb), 256'd97);
        chk("f2_done_edge", 256'(nd), 256'd199);
        chk("f2_matrix", matrix_a, exp2);
        chk("f2_popcount", 256'($countones(matrix_a)), 256'd8);
        @(posedge clk); #1;

        // Frame 3: negative x, only column 0 survives.
        set_part(0, -32, 128);
        part_valid = 4'b0001;
        run_frame(nb, nd);
        chk("f3_done_edge", 256'(nd), 256'd199);
        chk("f3_matrix", matrix_a, exp3);
        @(posedge clk); #1;

        // Frame 4: all particles valid, overlapping sprites and clipped bottom-right.
        set_part(0, 40, 40);
        set_part(1, 80, 48);
        set_part(2, 120, 230);
        set_part(3, 250, 250);
        part_valid = 4'hF;
        run_frame(nb, nd);
        chk("f4_done_latency", 256'(nd - nb), 256'd102);
        chk("f4_matrix", matrix_a, exp4);
        chk("f4_no_overrun", 256'(ov_a), 256'd0);
        @(posedge clk); #1;

        // Reset during DRAW cycle 40.
        for (int i = 0; i < NP; i++) set_part(i, 128, 128);
        part_valid = 4'b0001;
        n = 0;
        while ((n < 300) && !busy_a) begin
            @(posedge clk); #1;
            n++;
        end
        chk("r_busy_edge", 256'(n), 256'd97);
        repeat (41) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("r_matrix_clear", matrix_a, 256'd0);
        chk("r_busy_clear", 256'(busy_a), 256'd0);
        chk("r_done_clear", 256'(fd_a), 256'd0);
        @(negedge clk);
        reset = 1'b0;
        run_frame(nb, nd);
        chk("r2_busy_edge", 256'(nb), 256'd200);
        chk("r2_done_edge", 256'(nd), 256'd302);
        chk("r2_matrix", matrix_a, exp1);

        // Short frame period on dut_b: ticks at 50,100,150,200,250,300.
        @(negedge clk);
        enable_b = 1'b1;
        first_ov = -1;
        ov_cnt = 0;
        fd1 = -1;
        fd2 = -1;
        ov_at_101 = 1'b1;
        for (int k = 1; k <= 320; k++) begin
            @(posedge clk); #1;
            if (ov_b) begin
                ov_cnt++;
                if (first_ov < 0) first_ov = k;
            end
            if (k == 101) ov_at_101 = ov_b;
            if (fd_b) begin
                if (fd1 < 0) fd1 = k;
                else if (fd2 < 0) fd2 = k;
            end
        end
        chk("o_first_overrun", 256'(first_ov), 256'd100);
        chk("o_overrun_pulse", 256'(ov_at_101), 256'd0);
        chk("o_overrun_count", 256'(ov_cnt), 256'd4);
        chk("o_done1_edge", 256'(fd1), 256'd152);
        chk("o_done2_edge", 256'(fd2), 256'd302);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
